// File: rtl/ddr3_rw_tester.sv
// -----------------------------------------------------------------------------
// ddr3_rw_tester
//
// Self-checking traffic source and sink that sits in front of the DDR3
// controller's user ports. One pass writes WORDS pattern words over the fixed
// address window, waits SETTLE idle cycles, requests the same window back and
// compares every returned word against the regenerated pattern. The result of
// the last completed pass is held on pass / timeout / err_cnt / first_err_idx.
//
// Optional feature macro: DDR3_TEST_PRBS_EN
//   defined   : pattern is a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1),
//               seeded with 16'hACE1 ^ pass_cnt[15:0], widened/truncated to
//               DATA_IN_WIDTH.
//   undefined : pattern(i) = i + pass_cnt[15:0].
//
// Ports
//   clk, rst_n            user clock, asynchronous active-low reset
//   start                 level; begins a pass from IDLE once calibrated
//   loop                  sampled in DONE; chains straight into the next pass
//   init_calib_complete   controller calibration status
//   wr_req                one-cycle write request pulse
//   wr_address_beign/end  constant test window (ADDR_BEGIN / ADDR_END)
//   wr_din, wr_din_vld    write pattern word and its strobe
//   rd_req                one-cycle read request pulse
//   rd_address_beign/end  constant test window (ADDR_BEGIN / ADDR_END)
//   rd_dout, rd_dout_vld  returned word and its strobe
//   busy                  high in every state except IDLE and DONE
//   done                  one-cycle pulse on entry to DONE
//   pass, timeout         result of the last completed pass
//   err_cnt               mismatches in the last pass, saturating
//   first_err_idx         index of first mismatch, 16'hFFFF if none
//   pass_cnt              completed passes since reset, wrapping
// -----------------------------------------------------------------------------
module ddr3_rw_tester #(
    parameter int                    DATA_IN_WIDTH = 16,
    parameter int                    ADDR_WIDTH    = 28,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BEGIN    = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_END      = ADDR_WIDTH'(8184),
    parameter int                    WORDS         = 1024,
    parameter int                    SETTLE        = 256,
    parameter int                    TIMEOUT       = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     loop,
    input  logic                     init_calib_complete,
    output logic                     wr_req,
    output logic [ADDR_WIDTH-1:0]    wr_address_beign,
    output logic [ADDR_WIDTH-1:0]    wr_address_end,
    output logic [DATA_IN_WIDTH-1:0] wr_din,
    output logic                     wr_din_vld,
    output logic                     rd_req,
    output logic [ADDR_WIDTH-1:0]    rd_address_beign,
    output logic [ADDR_WIDTH-1:0]    rd_address_end,
    input  logic [DATA_IN_WIDTH-1:0] rd_dout,
    input  logic                     rd_dout_vld,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [15:0]              err_cnt,
    output logic [15:0]              first_err_idx,
    output logic [31:0]              pass_cnt
);

`ifdef DDR3_TEST_PRBS_EN
    localparam int PAT_W = 16;
`else
    localparam int PAT_W = DATA_IN_WIDTH;
`endif

    localparam logic [15:0] WORDS_L    = 16'(WORDS);
    localparam logic [15:0] WORDS_M1   = 16'(WORDS - 1);
    localparam logic [31:0] SETTLE_M1  = 32'(SETTLE - 1);
    localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_DATA, WR_WAIT, RD_REQ, RD_DATA, DONE
    } state_t;

    // Pattern generator state for the first word of a pass.
    function automatic logic [PAT_W-1:0] pat_seed(input logic [15:0] pc);
`ifdef DDR3_TEST_PRBS_EN
        logic [15:0] s;
        s = 16'hACE1 ^ pc;
        return (s == 16'h0000) ? 16'hACE1 : s;
`else
        return PAT_W'(pc);
`endif
    endfunction

    // Pattern generator state for the following word.
    function automatic logic [PAT_W-1:0] pat_next(input logic [PAT_W-1:0] p);
`ifdef DDR3_TEST_PRBS_EN
        logic [15:0] s;
        s = {p[0] ^ p[2] ^ p[3] ^ p[5], p[15:1]};
        return (s == 16'h0000) ? 16'hACE1 : s;
`else
        return p + PAT_W'(1);
`endif
    endfunction

    // Map generator state onto a user data word.
    function automatic logic [DATA_IN_WIDTH-1:0] pat_word(input logic [PAT_W-1:0] p);
`ifdef DDR3_TEST_PRBS_EN
        logic [DATA_IN_WIDTH-1:0] w;
        for (int i = 0; i < DATA_IN_WIDTH; i++) begin
            w[i] = p[i % 16];
        end
        return w;
`else
        return p;
`endif
    endfunction

    state_t                   state, state_nxt;
    logic [15:0]              wr_idx, rd_idx;
    logic [31:0]              settle_cnt, gap_cnt;
    logic [PAT_W-1:0]         wr_pat, rd_pat;
    logic                     vld_p0;
    logic [DATA_IN_WIDTH-1:0] rd_dout_p0, exp_p0;
    logic [15:0]              idx_p0;
    logic                     accept, mismatch_p0, last_wr, rd_complete, gap_expired;
    logic [15:0]              err_cnt_nxt;

    assign wr_address_beign = ADDR_BEGIN;
    assign wr_address_end   = ADDR_END;
    assign rd_address_beign = ADDR_BEGIN;
    assign rd_address_end   = ADDR_END;
    assign wr_din           = pat_word(wr_pat);

    // Words beyond the expected count are dropped so a late extra word
    // cannot disturb the final comparison.
    assign accept      = (state == RD_DATA) && rd_dout_vld && (rd_idx != WORDS_L);
    assign mismatch_p0 = vld_p0 && (rd_dout_p0 != exp_p0);
    assign last_wr     = (state == WR_DATA) && (wr_idx == WORDS_M1);
    assign rd_complete = (state == RD_DATA) && vld_p0 && (idx_p0 == WORDS_M1);
    // gap_cnt holds cycles since the last accepted word (or rd_req), so this
    // puts DONE exactly TIMEOUT cycles after that event.
    assign gap_expired = (state == RD_DATA) && !accept && (gap_cnt >= TIMEOUT_M1);

    always_comb begin
        err_cnt_nxt = err_cnt;
        if (mismatch_p0 && (err_cnt != 16'hFFFF)) begin
            err_cnt_nxt = err_cnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && init_calib_complete) state_nxt = WR_REQ;
            WR_REQ:  state_nxt = WR_DATA;
            WR_DATA: if (last_wr) state_nxt = (SETTLE == 0) ? RD_REQ : WR_WAIT;
            WR_WAIT: if (settle_cnt == SETTLE_M1) state_nxt = RD_REQ;
            RD_REQ:  state_nxt = RD_DATA;
            RD_DATA: if (rd_complete || gap_expired) state_nxt = DONE;
            DONE:    state_nxt = (loop && init_calib_complete) ? WR_REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_req        <= 1'b0;
            wr_din_vld    <= 1'b0;
            rd_req        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_cnt       <= 16'h0000;
            first_err_idx <= 16'hFFFF;
            pass_cnt      <= 32'd0;
            wr_idx        <= 16'd0;
            rd_idx        <= 16'd0;
            settle_cnt    <= 32'd0;
            gap_cnt       <= 32'd0;
            wr_pat        <= '0;
            vld_p0        <= 1'b0;
        end else begin
            state      <= state_nxt;
            // Strobes are registered from the next state so they line up
            // exactly with the state they describe.
            wr_req     <= (state_nxt == WR_REQ);
            wr_din_vld <= (state_nxt == WR_DATA);
            rd_req     <= (state_nxt == RD_REQ);
            busy       <= (state_nxt != IDLE) && (state_nxt != DONE);
            done       <= (state_nxt == DONE);
            vld_p0     <= accept;

            err_cnt <= err_cnt_nxt;
            if (mismatch_p0 && (first_err_idx == 16'hFFFF)) begin
                first_err_idx <= idx_p0;
            end
            if (gap_expired && !rd_complete) begin
                timeout <= 1'b1;
            end
            if (state_nxt == DONE) begin
                pass     <= (err_cnt_nxt == 16'h0000) && !(gap_expired && !rd_complete);
                pass_cnt <= pass_cnt + 32'd1;
            end

            case (state)
                WR_REQ: begin
                    wr_idx        <= 16'd0;
                    err_cnt       <= 16'h0000;
                    timeout       <= 1'b0;
                    first_err_idx <= 16'hFFFF;
                    wr_pat        <= pat_seed(pass_cnt[15:0]);
                end
                WR_DATA: begin
                    wr_idx     <= wr_idx + 16'd1;
                    wr_pat     <= pat_next(wr_pat);
                    settle_cnt <= 32'd0;
                end
                WR_WAIT: settle_cnt <= settle_cnt + 32'd1;
                RD_REQ: begin
                    rd_idx  <= 16'd0;
                    gap_cnt <= 32'd1;
                end
                RD_DATA: begin
                    if (accept) begin
                        rd_idx  <= rd_idx + 16'd1;
                        gap_cnt <= 32'd1;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---- stage p0: capture returned word with its expected value ----
    always_ff @(posedge clk) begin
        if (state == RD_REQ) begin
            rd_pat <= pat_seed(pass_cnt[15:0]);
        end else if (accept) begin
            rd_pat <= pat_next(rd_pat);
        end
        rd_dout_p0 <= rd_dout;
        exp_p0     <= pat_word(rd_pat);
        idx_p0     <= rd_idx;
    end

endmodule

// File: tb/tb_ddr3_rw_tester.sv
// -----------------------------------------------------------------------------
// tb_ddr3_rw_tester
//
// Directed bench for ddr3_rw_tester with WORDS=16, SETTLE=4, TIMEOUT=100 and
// the incrementing pattern. A loopback memory captures the write stream and
// replays it on the read port, optionally corrupting or dropping words.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ddr3_rw_tester;

    localparam int DW      = 16;
    localparam int AW      = 28;
    localparam int WORDS   = 16;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, loop, init_calib_complete;
    logic          wr_req, wr_din_vld, rd_req, rd_dout_vld;
    logic [AW-1:0] wr_address_beign, wr_address_end, rd_address_beign, rd_address_end;
    logic [DW-1:0] wr_din, rd_dout;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_cnt, first_err_idx;
    logic [31:0]   pass_cnt;

    always #5 clk = ~clk;

    ddr3_rw_tester #(
        .DATA_IN_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_BEGIN('0), .ADDR_END(28'd8184),
        .WORDS(WORDS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .loop(loop),
        .init_calib_complete(init_calib_complete),
        .wr_req(wr_req), .wr_address_beign(wr_address_beign), .wr_address_end(wr_address_end),
        .wr_din(wr_din), .wr_din_vld(wr_din_vld),
        .rd_req(rd_req), .rd_address_beign(rd_address_beign), .rd_address_end(rd_address_end),
        .rd_dout(rd_dout), .rd_dout_vld(rd_dout_vld),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .first_err_idx(first_err_idx), .pass_cnt(pass_cnt)
    );

    int errors = 0;
    int checks = 0;
    int exp_pc = 0;
    logic [DW-1:0] mem [WORDS];

    typedef struct {
        int          nwords;
        int          bad_a;
        int          bad_b;
        logic        exp_pass;
        logic [15:0] exp_err;
        logic [15:0] exp_first;
        logic        exp_to;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete pass; start/loop are set by the caller. Returns in the
    // cycle where done is seen (or after the bound expires).
    task automatic run_pass(input string tag, input int nwords, input int bad_a, input int bad_b,
                            input logic exp_pass, input logic [15:0] exp_err,
                            input logic [15:0] exp_first, input logic exp_to);
        int          k;
        bit          seen;
        bit          early_done;
        logic [15:0] seed;
        logic [DW-1:0] flip;
        seed = 16'(exp_pc);
        seen = 1'b0;
        for (k = 0; k < 50; k++) begin
            if (wr_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, " wr_req_seen"}, 32'(seen), 32'd1);
        check({tag, " busy_wr_req"}, 32'(busy), 32'd1);
        start = 1'b0;

        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk);
            check({tag, " wr_din_vld"}, 32'(wr_din_vld), 32'd1);
            check({tag, " wr_din"}, 32'(wr_din), 32'(16'(i) + seed));
            if (i == 0) check({tag, " wr_req_pulse"}, 32'(wr_req), 32'd0);
            mem[i] = wr_din;
        end

        // Junk strobes before the read phase must be ignored.
        for (k = 1; k <= SETTLE + 20; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, " wr_din_vld_end"}, 32'(wr_din_vld), 32'd0);
            if (rd_req) break;
            rd_dout_vld = 1'b1;
            rd_dout     = 16'hDEAD;
        end
        check({tag, " rd_req_delay"}, 32'(k), 32'(SETTLE + 1));
        rd_dout_vld = 1'b1;
        rd_dout     = 16'hBEEF;
        @(negedge clk);
        check({tag, " rd_req_pulse"}, 32'(rd_req), 32'd0);
        rd_dout_vld = 1'b0;
        @(negedge clk);

        early_done = 1'b0;
        for (int j = 0; j < nwords; j++) begin
            if (j % 4 == 3) begin
                @(negedge clk);
                if (done) early_done = 1'b1;
                rd_dout_vld = 1'b0;
            end
            @(negedge clk);
            if (done) early_done = 1'b1;
            flip        = (j == bad_a || j == bad_b) ? 16'h0001 : 16'h0000;
            rd_dout_vld = 1'b1;
            rd_dout     = mem[j] ^ flip;
        end
        check({tag, " no_early_done"}, 32'(early_done), 32'd0);

        seen = 1'b0;
        for (k = 1; k <= TIMEOUT + 20; k++) begin
            @(negedge clk);
            rd_dout_vld = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " done_latency"}, 32'(k), (nwords == WORDS) ? 32'd2 : 32'(TIMEOUT));
        check({tag, " pass"}, 32'(pass), 32'(exp_pass));
        check({tag, " err_cnt"}, 32'(err_cnt), 32'(exp_err));
        check({tag, " first_err_idx"}, 32'(first_err_idx), 32'(exp_first));
        check({tag, " timeout"}, 32'(timeout), 32'(exp_to));
        check({tag, " pass_cnt"}, pass_cnt, 32'(exp_pc + 1));
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        exp_pc++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " wr_req"}, 32'(wr_req), 32'd0);
        check({tag, " wr_din_vld"}, 32'(wr_din_vld), 32'd0);
        check({tag, " wr_din"}, 32'(wr_din), 32'd0);
        check({tag, " rd_req"}, 32'(rd_req), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " pass"}, 32'(pass), 32'd0);
        check({tag, " timeout"}, 32'(timeout), 32'd0);
        check({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, " first_err_idx"}, 32'(first_err_idx), 32'h0000FFFF);
        check({tag, " pass_cnt"}, pass_cnt, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit stray;
        vecs[0] = '{16, -1, -1, 1'b1, 16'd0, 16'hFFFF, 1'b0};
        vecs[1] = '{16,  5, -1, 1'b0, 16'd1, 16'd5,    1'b0};
        vecs[2] = '{16,  5,  9, 1'b0, 16'd2, 16'd5,    1'b0};
        vecs[3] = '{15, -1, -1, 1'b0, 16'd0, 16'hFFFF, 1'b1};
        vecs[4] = '{16,  0, 15, 1'b0, 16'd2, 16'd0,    1'b0};
        vecs[5] = '{16, -1, -1, 1'b1, 16'd0, 16'hFFFF, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        loop  = 1'b0;
        init_calib_complete = 1'b0;
        rd_dout     = '0;
        rd_dout_vld = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        check("wr_address_beign", 32'(wr_address_beign), 32'd0);
        check("wr_address_end", 32'(wr_address_end), 32'd8184);
        check("rd_address_beign", 32'(rd_address_beign), 32'd0);
        check("rd_address_end", 32'(rd_address_end), 32'd8184);
        rst_n = 1'b1;

        // Calibration gating: start alone must not begin a pass.
        start = 1'b1;
        stray = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (wr_req || busy) stray = 1'b1;
        end
        check("calib_gate_idle", 32'(stray), 32'd0);
        init_calib_complete = 1'b1;
        @(negedge clk);
        check("calib_wr_req_next", 32'(wr_req), 32'd1);
        run_pass("calib_pass", WORDS, -1, -1, 1'b1, 16'd0, 16'hFFFF, 1'b0);

        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            start = 1'b1;
            run_pass($sformatf("vec%0d", v), vecs[v].nwords, vecs[v].bad_a, vecs[v].bad_b,
                     vecs[v].exp_pass, vecs[v].exp_err, vecs[v].exp_first, vecs[v].exp_to);
        end

        // Reset asserted in the middle of the write burst.
        @(negedge clk);
        start = 1'b1;
        stray = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (wr_req) begin
                stray = 1'b0;
                break;
            end
        end
        check("rst_mid wr_req_seen", 32'(stray), 32'd0);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid in_wr_data", 32'(wr_din_vld), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_values("rst_mid_async");
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (wr_din_vld) stray = 1'b1;
        end
        check("rst_mid no_wr_din_vld", 32'(stray), 32'd0);
        rst_n  = 1'b1;
        exp_pc = 0;

        // Three chained passes from reset: seeds 0, 1, 2.
        @(negedge clk);
        loop  = 1'b1;
        start = 1'b1;
        run_pass("loop1", WORDS, -1, -1, 1'b1, 16'd0, 16'hFFFF, 1'b0);
        run_pass("loop2", WORDS, -1, -1, 1'b1, 16'd0, 16'hFFFF, 1'b0);
        run_pass("loop3", WORDS, -1, -1, 1'b1, 16'd0, 16'hFFFF, 1'b0);
        loop  = 1'b0;
        stray = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (wr_req || busy) stray = 1'b1;
        end
        check("loop_end idle", 32'(stray), 32'd0);
        check("loop_end pass_cnt", pass_cnt, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr3_rw_tester.md
# ddr3_rw_tester

Self-checking traffic source and sink placed directly upstream of the DDR3 controller top. Writes a deterministic pattern over a fixed address window through the controller's user write port, then requests the same window back through the user read port. Compares every returned word against the regenerated pattern and reports pass/fail, error count and first failing index. Used for board bring-up and soak testing; `wr_clk` and `rd_clk` of the controller are both driven from this block's `clk`.

## Interface
- `DATA_IN_WIDTH`, 16: user data width; matches the controller's `DATA_IN_WIDTH`.
- `ADDR_WIDTH`, 28: user address width.
- `ADDR_BEGIN`, 0: first address of the test window, driven on `wr_address_beign` and `rd_address_beign`.
- `ADDR_END`, 28'd8184: last address of the test window, driven on `wr_address_end` and `rd_address_end`.
- `WORDS`, 1024: user words per pass; range 1..65535.
- `SETTLE`, 256: idle cycles between the last write word and `rd_req`.
- `TIMEOUT`, 65535: maximum gap in cycles between read words before a pass is aborted.

Ports:
- `clk`  in  1: user clock; also drives the controller's `wr_clk` and `rd_clk`.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: level; when high in IDLE and calibration is complete, a pass begins.
- `loop`  in  1: sampled in DONE; when high, the next pass starts automatically.
- `init_calib_complete`  in  1: from the controller.
- `wr_req`  out  1: one-cycle write-request pulse.
- `wr_address_beign`, `wr_address_end`  out  ADDR_WIDTH: constant `ADDR_BEGIN` / `ADDR_END`.
- `wr_din`  out  DATA_IN_WIDTH: write pattern word.
- `wr_din_vld`  out  1: write word strobe.
- `rd_req`  out  1: one-cycle read-request pulse.
- `rd_address_beign`, `rd_address_end`  out  ADDR_WIDTH: constant `ADDR_BEGIN` / `ADDR_END`.
- `rd_dout`  in  DATA_IN_WIDTH: returned word.
- `rd_dout_vld`  in  1: returned-word strobe.
- `busy`  out  1: high in any state other than IDLE and DONE.
- `done`  out  1: one-cycle pulse on entry to DONE.
- `pass`  out  1: result of the last completed pass.
- `timeout`  out  1: last pass aborted on read timeout.
- `err_cnt`  out  16: mismatches in the last pass; saturates at 16'hFFFF.
- `first_err_idx`  out  16: word index of the first mismatch; 16'hFFFF if none.
- `pass_cnt`  out  32: completed passes since reset; wraps.

## Operation
- States: IDLE, WR_REQ, WR_DATA, WR_WAIT, RD_REQ, RD_DATA, DONE.
- IDLE -> WR_REQ when `start & init_calib_complete`.
- WR_REQ: `wr_req`=1 for one cycle; clear the word index, `err_cnt`, `timeout` and `first_err_idx` (to 16'hFFFF); load the pattern generator with the pass seed. Then -> WR_DATA.
- WR_DATA: `wr_din_vld`=1 on every cycle for exactly `WORDS` cycles, with `wr_din` = pattern(index). -> WR_WAIT after index `WORDS`-1.
- WR_WAIT: count `SETTLE` cycles -> RD_REQ.
- RD_REQ: `rd_req`=1 for one cycle; reload the pattern generator with the same seed; clear the read index and gap counter. Then -> RD_DATA.
- RD_DATA: on each `rd_dout_vld`, compare `rd_dout` with the expected word and increment the read index. On a mismatch, increment `err_cnt` (saturating) and capture the index into `first_err_idx` if it is still 16'hFFFF.
  - After `WORDS` words -> DONE.
  - If the gap counter reaches `TIMEOUT` -> DONE with `timeout`=1.
  - `rd_dout_vld` while in any state other than RD_DATA is ignored.
- DONE: `done` pulses, `pass` = (`err_cnt`==0 && !`timeout`), `pass_cnt`++. Then -> WR_REQ if `loop & init_calib_complete`, otherwise -> IDLE.
- Pattern without the macro: pattern(i) = i + seed, truncated to DATA_IN_WIDTH. The seed is `pass_cnt[15:0]`, zero-extended.
- `init_calib_complete` falling mid-pass: no abort; the pass completes or times out.

## Timing
- Reset values: all outputs 0, except `first_err_idx` = 16'hFFFF. The address outputs are constants.
- `wr_req` is asserted in cycle T. The first `wr_din_vld` is in cycle T+1; the last is in cycle T+`WORDS`.
- `rd_req` is asserted `SETTLE`+1 cycles after the last `wr_din_vld`.
- Comparison is registered, one cycle after `rd_dout_vld`. DONE is entered 2 cycles after the final `rd_dout_vld`; `done`, `pass`, `err_cnt` and `first_err_idx` are valid together in that cycle.
- All outputs are registered. `start` is level-sensitive and not edge-detected.

## Configuration
- `DDR3_TEST_PRBS_EN` defined: pattern is a 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, seeded with 16'hACE1 ^ `pass_cnt[15:0]`. It advances once per word and is replicated or truncated to DATA_IN_WIDTH. A zero state is forced to 16'hACE1.
- Not defined: incrementing pattern as described in Operation.

## Test plan
- Loopback memory model, `WORDS`=16, `start` pulsed -> 16 `wr_din_vld` words 0..15, one `rd_req`, `done` pulse, `pass`=1, `err_cnt`=0, `first_err_idx`=16'hFFFF, `pass_cnt`=1.
- Model corrupts read word 5 (bit 0 flipped) -> `pass`=0, `err_cnt`=1, `first_err_idx`=5.
- Model returns only 15 of 16 words, `TIMEOUT`=100 -> DONE 100 cycles after the last word, `timeout`=1, `pass`=0.
- `loop`=1 for 3 passes -> `pass_cnt`=3; second pass writes 1..16 (seed 1).
- `init_calib_complete`=0 with `start`=1 -> remains IDLE, `wr_req` never asserted; asserting calibration -> `wr_req` on the next cycle.
- `rst_n` low during WR_DATA -> all outputs return to reset values immediately; no further `wr_din_vld`. Release plus `start` -> a clean pass with `pass_cnt`=1.
